pmul_sideband_fifo: RTL

PMUL_SIDEBAND_FIFO -- requirements
Module: pmul_sideband_fifo

---
 rtl/pmul_sideband_fifo_pkg.sv | 19 +
 rtl/pmul_pipe.sv | 52 +++++
 rtl/pmul_sideband_fifo.sv | 94 +++++++++
 3 files changed

// File: rtl/pmul_sideband_fifo_pkg.sv
// Shared defaults and sideband record for the multiplier/divider datapath.
// Used by the product FIFO and the Goldschmidt iteration blocks.
package pmul_sideband_fifo_pkg;

  localparam int DEF_MANT_W = 24;
  localparam int DEF_EXP_W  = 8;
  localparam int DEF_LAT    = 3;
  localparam int DEF_DEPTH  = 8;

  typedef struct packed {
    logic                 sign;
    logic [DEF_EXP_W-1:0] exponent;
  } sideband_t;

  function automatic int sb_width(input int exp_w);
    return exp_w + 1;
  endfunction

endpackage

// File: rtl/pmul_pipe.sv
// LAT-stage unsigned multiplier carrying a sideband word and valid bit
// in lock-step with the product.
module pmul_pipe
  import pmul_sideband_fifo_pkg::*;
#(
  parameter int MANT_W = DEF_MANT_W,
  parameter int SB_W   = sb_width(DEF_EXP_W),
  parameter int LAT    = DEF_LAT
) (
  input  logic                clk,
  input  logic                clear_b,
  input  logic                flush,
  input  logic                i_valid,
  input  logic [MANT_W-1:0]   i_a,
  input  logic [MANT_W-1:0]   i_b,
  input  logic [SB_W-1:0]     i_sb,
  output logic                o_valid,
  output logic [2*MANT_W-1:0] o_prod,
  output logic [SB_W-1:0]     o_sb
);

  logic [LAT-1:0]      r_vld;
  logic [2*MANT_W-1:0] r_prod [LAT];
  logic [SB_W-1:0]     r_sb   [LAT];
  logic [2*MANT_W-1:0] w_prod;

  assign w_prod = {{MANT_W{1'b0}}, i_a} * {{MANT_W{1'b0}}, i_b};

  always_ff @(posedge clk) begin
    if (!clear_b || flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_valid;
      for (int i = 1; i < LAT; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  // Data stages carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    r_prod[0] <= w_prod;
    r_sb[0]   <= i_sb;
    for (int i = 1; i < LAT; i++) begin
      r_prod[i] <= r_prod[i-1];
      r_sb[i]   <= r_sb[i-1];
    end
  end

  assign o_valid = r_vld[LAT-1];
  assign o_prod  = r_prod[LAT-1];
  assign o_sb    = r_sb[LAT-1];

endmodule

// File: rtl/pmul_sideband_fifo.sv
// Pipelined multiplier feeding a credit-controlled result FIFO; the level
// counts FIFO entries plus in-flight items so every accept owns a slot.
module pmul_sideband_fifo
  import pmul_sideband_fifo_pkg::*;
#(
  parameter int MANT_W = DEF_MANT_W,
  parameter int EXP_W  = DEF_EXP_W,
  parameter int LAT    = DEF_LAT,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       clear_b,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MANT_W-1:0]          a_in,
  input  logic [MANT_W-1:0]          b_in,
  input  logic                       sign_q,
  input  logic [EXP_W-1:0]           exponent_q,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*MANT_W-1:0]        product,
  output logic                       sign_passed,
  output logic [EXP_W-1:0]           exponent_passed,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int SB_W = sb_width(EXP_W);

  logic [LW-1:0]       r_level;
  logic [LW-1:0]       r_cnt;
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [2*MANT_W-1:0] r_mem [DEPTH];
  logic [SB_W-1:0]     r_sbm [DEPTH];

  logic                w_kill;
  logic                w_accept;
  logic                w_pop;
  logic                w_wr;
  logic [2*MANT_W-1:0] w_pprod;
  logic [SB_W-1:0]     w_psb;

  assign w_kill    = !clear_b || flush;
  assign in_ready  = clear_b && !flush && (r_level < LW'(DEPTH));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_cnt != '0);
  assign w_pop     = out_valid && out_ready && !w_kill;

  pmul_pipe #(
    .MANT_W (MANT_W),
    .SB_W   (SB_W),
    .LAT    (LAT)
  ) u_pipe (
    .clk     (clk),
    .clear_b (clear_b),
    .flush   (flush),
    .i_valid (w_accept),
    .i_a     (a_in),
    .i_b     (b_in),
    .i_sb    ({sign_q, exponent_q}),
    .o_valid (w_wr),
    .o_prod  (w_pprod),
    .o_sb    (w_psb)
  );

  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_level <= '0;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_level <= r_level + LW'(w_accept) - LW'(w_pop);
      r_cnt   <= r_cnt + LW'(w_wr) - LW'(w_pop);
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_pprod;
      r_sbm[r_wptr] <= w_psb;
    end
  end

  assign product                        = r_mem[r_rptr];
  assign {sign_passed, exponent_passed} = r_sbm[r_rptr];
  assign level                          = r_level;

endmodule
